// File: rtl/dfd_tn_pkg.sv
// rtl/dfd_tn_pkg.sv - shared types and constants for the trace-network interface
package dfd_tn_pkg;

    localparam int TNIF_DW_B = 16;
    localparam int TNIF_DW   = TNIF_DW_B * 8;

    localparam logic TNIF_SRC_NTRACE = 1'b0;
    localparam logic TNIF_SRC_DST    = 1'b1;

    typedef struct packed {
        logic               src;
        logic [TNIF_DW-1:0] data;
    } TnifFlit_s;

endpackage

// File: rtl/dfd_tnif_flit_fifo.sv
// rtl/dfd_tnif_flit_fifo.sv - 2-write/1-read flit FIFO with registered occupancy and free count
import dfd_tn_pkg::*;

module dfd_tnif_flit_fifo #(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr0_vld,
    input  TnifFlit_s        wr0_flit,
    input  logic             wr1_vld,
    input  TnifFlit_s        wr1_flit,
    input  logic             rd_en,
    output TnifFlit_s        head,
    output logic             empty,
    output logic [CNT_W-1:0] free
);

    TnifFlit_s        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    assign count_nxt = count + CNT_W'(wr0_vld) + CNT_W'(wr1_vld) - CNT_W'(rd_en);

    // wr1 lands behind wr0 when both fire, preserving close order
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            free   <= CNT_W'(DEPTH);
        end else begin
            if (wr0_vld) begin
                mem[wr_ptr] <= wr0_flit;
            end
            if (wr1_vld) begin
                mem[wr_ptr + PTR_W'(wr0_vld)] <= wr1_flit;
            end
            wr_ptr <= wr_ptr + PTR_W'(wr0_vld) + PTR_W'(wr1_vld);
            rd_ptr <= rd_ptr + PTR_W'(rd_en);
            count  <= count_nxt;
            free   <= CNT_W'(DEPTH) - count_nxt;
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/dfd_tnif_packer.sv
// rtl/dfd_tnif_packer.sv - packs variable-length trace messages into flits for one trace-network lane
import dfd_tn_pkg::*;

module dfd_tnif_packer #(
    parameter int  DATA_WIDTH_IN_BYTES = TNIF_DW_B,
    parameter int  DATA_WIDTH          = DATA_WIDTH_IN_BYTES * 8,
    parameter int  FIFO_DEPTH          = 4,
    localparam int FILL_W              = $clog2(DATA_WIDTH_IN_BYTES),
    localparam int LEN_W               = FILL_W + 1,
    localparam int CNT_W               = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_tnif_en,
    input  logic                  i_msg_vld,
    output logic                  o_msg_rdy,
    input  logic                  i_msg_src,
    input  logic [LEN_W-1:0]      i_msg_len,
    input  logic [DATA_WIDTH-1:0] i_msg_data,
    output logic                  MS_TN_Vld,
    output logic                  MS_TN_Src,
    output logic [DATA_WIDTH-1:0] MS_TN_Data,
    input  logic                  TN_MS_Gnt,
    input  logic                  TN_MS_Ntrace_Bp,
    input  logic                  TN_MS_Dst_Bp,
    input  logic                  TN_MS_Ntrace_Flush,
    input  logic                  TN_MS_Dst_Flush,
    output logic                  o_fifo_empty
);

    // Places len message bytes at byte offset fill on top of base; the upper
    // half of the result is the spill-over that starts the next partial flit.
    function automatic logic [2*DATA_WIDTH-1:0] align_msg(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] msg,
        input logic [FILL_W-1:0]     fill,
        input logic [LEN_W-1:0]      len
    );
        logic [2*DATA_WIDTH-1:0] r;
        r = {{DATA_WIDTH{1'b0}}, base};
        for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
            if (LEN_W'(i) < len) begin
                r[(int'(fill) + i)*8 +: 8] = msg[i*8 +: 8];
            end
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0]   pbuf;
    logic [FILL_W-1:0]       pfill;
    logic                    psrc;
    logic                    pvld;

    logic                    flush_close;
    logic                    flush_push;
    logic                    accept;
    logic                    src_switch;
    logic [FILL_W-1:0]       base_fill;
    logic [DATA_WIDTH-1:0]   base_buf;
    logic [2*DATA_WIDTH-1:0] aligned;
    logic [LEN_W-1:0]        total;
    logic                    complete;

    logic                    wr0_vld;
    logic                    wr1_vld;
    TnifFlit_s               wr0_flit;
    TnifFlit_s               wr1_flit;
    TnifFlit_s               head;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        free;
    logic                    pop;

    assign pvld        = (pfill != '0);
    assign flush_close = pvld & ((psrc == TNIF_SRC_NTRACE & TN_MS_Ntrace_Flush) |
                                 (psrc == TNIF_SRC_DST    & TN_MS_Dst_Flush));
    assign flush_push  = flush_close & (free != '0);

    // Ready depends only on registered occupancy so grant never reaches it
    assign o_msg_rdy = reset_n & (!i_tnif_en | ((free >= CNT_W'(2)) & !flush_close));
    assign accept    = i_msg_vld & o_msg_rdy & i_tnif_en;

    assign src_switch = pvld & (psrc != i_msg_src);
    assign base_fill  = src_switch ? '0 : pfill;
    assign base_buf   = src_switch ? '0 : pbuf;
    assign aligned    = align_msg(base_buf, i_msg_data, base_fill, i_msg_len);
    assign total      = LEN_W'(base_fill) + i_msg_len;
    assign complete   = (total >= LEN_W'(DATA_WIDTH_IN_BYTES));

    always_comb begin
        wr0_vld  = 1'b0;
        wr1_vld  = 1'b0;
        wr0_flit = '{src: psrc, data: pbuf};
        wr1_flit = '{src: i_msg_src, data: aligned[DATA_WIDTH-1:0]};
        if (flush_push) begin
            wr0_vld = 1'b1;
        end else if (accept) begin
            wr0_vld = src_switch | complete;
            wr1_vld = src_switch & complete;
            if (!src_switch) begin
                wr0_flit = '{src: i_msg_src, data: aligned[DATA_WIDTH-1:0]};
            end
        end
    end

    // Bytes above pfill in pbuf are kept zero, so closing a partial needs no masking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pbuf  <= '0;
            pfill <= '0;
            psrc  <= TNIF_SRC_NTRACE;
        end else if (flush_push) begin
            pbuf  <= '0;
            pfill <= '0;
        end else if (accept) begin
            psrc <= i_msg_src;
            if (complete) begin
                pbuf  <= aligned[2*DATA_WIDTH-1:DATA_WIDTH];
                pfill <= FILL_W'(total - LEN_W'(DATA_WIDTH_IN_BYTES));
            end else begin
                pbuf  <= aligned[DATA_WIDTH-1:0];
                pfill <= FILL_W'(total);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (CNT_W'(wr0_vld) + CNT_W'(wr1_vld) <= free);
        end
    end

    dfd_tnif_flit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_flit_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr0_vld  (wr0_vld),
        .wr0_flit (wr0_flit),
        .wr1_vld  (wr1_vld),
        .wr1_flit (wr1_flit),
        .rd_en    (pop),
        .head     (head),
        .empty    (fifo_empty),
        .free     (free)
    );

    assign MS_TN_Vld    = !fifo_empty & !(head.src ? TN_MS_Dst_Bp : TN_MS_Ntrace_Bp);
    assign MS_TN_Src    = head.src;
    assign MS_TN_Data   = head.data;
    assign pop          = MS_TN_Vld & TN_MS_Gnt;
    assign o_fifo_empty = fifo_empty & !pvld;

endmodule

// File: tb/tb_dfd_tnif_packer.sv
// tb/tb_dfd_tnif_packer.sv - scoreboard bench for dfd_tnif_packer
module tb_dfd_tnif_packer;

    localparam int DWB = 16;
    localparam int DW  = DWB * 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_tnif_en;
    logic          i_msg_vld;
    logic          o_msg_rdy;
    logic          i_msg_src;
    logic [4:0]    i_msg_len;
    logic [DW-1:0] i_msg_data;
    logic          MS_TN_Vld;
    logic          MS_TN_Src;
    logic [DW-1:0] MS_TN_Data;
    logic          TN_MS_Gnt;
    logic          TN_MS_Ntrace_Bp;
    logic          TN_MS_Dst_Bp;
    logic          TN_MS_Ntrace_Flush;
    logic          TN_MS_Dst_Flush;
    logic          o_fifo_empty;

    typedef struct {
        logic          src;
        logic [DW-1:0] data;
    } exp_flit_t;

    exp_flit_t  exp_q[$];
    logic [7:0] m_bytes[$];
    logic       m_src;
    int         n_checks;
    int         n_fail;

    always #5 clk = ~clk;

    dfd_tnif_packer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .i_tnif_en          (i_tnif_en),
        .i_msg_vld          (i_msg_vld),
        .o_msg_rdy          (o_msg_rdy),
        .i_msg_src          (i_msg_src),
        .i_msg_len          (i_msg_len),
        .i_msg_data         (i_msg_data),
        .MS_TN_Vld          (MS_TN_Vld),
        .MS_TN_Src          (MS_TN_Src),
        .MS_TN_Data         (MS_TN_Data),
        .TN_MS_Gnt          (TN_MS_Gnt),
        .TN_MS_Ntrace_Bp    (TN_MS_Ntrace_Bp),
        .TN_MS_Dst_Bp       (TN_MS_Dst_Bp),
        .TN_MS_Ntrace_Flush (TN_MS_Ntrace_Flush),
        .TN_MS_Dst_Flush    (TN_MS_Dst_Flush),
        .o_fifo_empty       (o_fifo_empty)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference packer: a plain byte queue closed every DWB bytes or on source change
    task automatic model_close(input logic s);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DWB; i++) begin
            if (m_bytes.size() != 0) d[i*8 +: 8] = m_bytes.pop_front();
        end
        exp_q.push_back('{src: s, data: d});
    endtask

    task automatic model_msg(input logic s, input int len, input logic [DW-1:0] data);
        if (m_bytes.size() != 0 && m_src != s) model_close(m_src);
        m_src = s;
        for (int i = 0; i < len; i++) m_bytes.push_back(data[i*8 +: 8]);
        if (m_bytes.size() >= DWB) model_close(s);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send(input logic s, input int len, input logic [DW-1:0] data);
        int n;
        i_msg_vld  = 1'b1;
        i_msg_src  = s;
        i_msg_len  = 5'(len);
        i_msg_data = data;
        n = 0;
        @(negedge clk);
        while (!o_msg_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_msg_rdy) check_val("rdy_timeout", 0, 1);
        else if (i_tnif_en) model_msg(s, len, data);
        @(posedge clk); #1;
        i_msg_vld = 1'b0;
    endtask

    task automatic probe_rdy(input string tag, input logic exp);
        i_msg_vld = 1'b1;
        @(negedge clk);
        check_val(tag, o_msg_rdy, exp);
        i_msg_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic flush_pulse(input logic is_dst, input logic closes);
        TN_MS_Ntrace_Flush = !is_dst;
        TN_MS_Dst_Flush    = is_dst;
        @(negedge clk);
        check_val(is_dst ? "dst_flush_rdy" : "nt_flush_rdy", o_msg_rdy, !closes);
        if (closes) model_close(m_src);
        @(posedge clk); #1;
        TN_MS_Ntrace_Flush = 1'b0;
        TN_MS_Dst_Flush    = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && MS_TN_Vld && TN_MS_Gnt) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_flit", 1, 0);
            end else begin
                exp_flit_t e;
                e = exp_q.pop_front();
                check_val("flit_src", MS_TN_Src, e.src);
                check_val("flit_data", MS_TN_Data, e.data);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        m_src = 1'b0;
        reset_n = 1'b0;
        i_tnif_en = 1'b1;
        i_msg_vld = 1'b0;
        i_msg_src = 1'b0;
        i_msg_len = 5'd1;
        i_msg_data = '0;
        TN_MS_Gnt = 1'b1;
        TN_MS_Ntrace_Bp = 1'b0;
        TN_MS_Dst_Bp = 1'b0;
        TN_MS_Ntrace_Flush = 1'b0;
        TN_MS_Dst_Flush = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rdy", o_msg_rdy, 0);
        check_val("rst_vld", MS_TN_Vld, 0);
        check_val("rst_src", MS_TN_Src, 0);
        check_val("rst_data", MS_TN_Data, 0);
        check_val("rst_empty", o_fifo_empty, 1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // four 4-byte N-Trace messages make exactly one flit
        send(0, 4, {{(DW-32){1'b1}}, {4{8'h11}}});
        send(0, 4, {4{8'h22}});
        send(0, 4, {4{8'h33}});
        check_val("pre_vld", MS_TN_Vld, 0);
        send(0, 4, {4{8'h44}});
        check_val("lat_vld", MS_TN_Vld, 1);
        check_val("lat_data", MS_TN_Data, {{4{8'h44}}, {4{8'h33}}, {4{8'h22}}, {4{8'h11}}});
        wait_drain("drain_t1");
        check_val("empty_t1", o_fifo_empty, 1);

        // source switch closes a 10-byte N-Trace partial
        send(0, 10, rnd128());
        send(1, 8, rnd128());
        wait_drain("drain_t2");
        check_val("dst_partial_held", o_fifo_empty, 0);

        // pfill 12 + 8 bytes spills 4; fill FIFO so ready drops
        TN_MS_Gnt = 1'b0;
        send(1, 4, rnd128());
        send(1, 8, rnd128());
        send(1, 16, rnd128());
        send(1, 16, rnd128());
        probe_rdy("rdy_low_free1", 0);

        // DST backpressure holds the head
        TN_MS_Dst_Bp = 1'b1;
        TN_MS_Gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_vld", MS_TN_Vld, 0);
            check_val("bp_head", MS_TN_Data, exp_q[0].data);
        end
        @(posedge clk); #1;
        TN_MS_Dst_Bp = 1'b0;
        wait_drain("drain_t4");

        // lane disabled: accepted and dropped, partial untouched
        i_tnif_en = 1'b0;
        probe_rdy("dis_rdy", 1);
        send(0, 7, rnd128());
        i_tnif_en = 1'b1;

        // 3-byte N-Trace partial (closes DST remainder), flushes
        send(0, 3, rnd128());
        wait_drain("drain_t5a");
        flush_pulse(1'b1, 1'b0);
        check_val("dst_flush_noop", o_fifo_empty, 0);
        flush_pulse(1'b0, 1'b1);
        wait_drain("drain_t5b");
        check_val("empty_after_flush", o_fifo_empty, 1);

        // fill FIFO completely, then reset discards everything
        TN_MS_Gnt = 1'b0;
        send(0, 16, rnd128());
        send(0, 16, rnd128());
        send(0, 4, rnd128());
        send(1, 16, rnd128());
        probe_rdy("rdy_low_full", 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_val("mid_rst_rdy", o_msg_rdy, 0);
        check_val("mid_rst_vld", MS_TN_Vld, 0);
        check_val("mid_rst_src", MS_TN_Src, 0);
        check_val("mid_rst_data", MS_TN_Data, 0);
        check_val("mid_rst_empty", o_fifo_empty, 1);
        reset_n = 1'b1;
        exp_q.delete();
        m_bytes.delete();
        TN_MS_Gnt = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("no_stale_vld", MS_TN_Vld, 0);
        check_val("no_stale_empty", o_fifo_empty, 1);
        send(1, 16, rnd128());
        wait_drain("drain_t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
